// File: rtl/signed_minmax_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : minmax_pkg
// Description : Shared state encoding and default sizing for the signed
//               min/max tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package minmax_pkg;

    localparam int c_default_width   = 8;
    localparam int c_default_max_len = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage : minmax_pkg
`default_nettype wire

// File: rtl/signed_minmax_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : signed_minmax_tracker_if
// Description : Sample stream in, per-frame result stream out.
// Revision    : 1.0 - initial release
// ============================================================================
interface signed_minmax_tracker_if #(
    parameter int WIDTH = minmax_pkg::c_default_width,
    parameter int IDX_W = $clog2(minmax_pkg::c_default_max_len),
    parameter int CNT_W = $clog2(minmax_pkg::c_default_max_len + 1)
) ();

    logic                    s_valid;
    logic                    s_ready;
    logic signed [WIDTH-1:0] s_data;
    logic                    s_last;

    logic                    m_valid;
    logic                    m_ready;
    logic signed [WIDTH-1:0] m_min;
    logic signed [WIDTH-1:0] m_max;
    logic [IDX_W-1:0]        m_min_idx;
    logic [IDX_W-1:0]        m_max_idx;
    logic [CNT_W-1:0]        m_count;
    logic                    m_trunc;

    // The tracker itself is the slave; the sample source / result sink is the master.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_min, m_max, m_min_idx, m_max_idx, m_count, m_trunc
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_min, m_max, m_min_idx, m_max_idx, m_count, m_trunc
    );

endinterface : signed_minmax_tracker_if
`default_nettype wire

// File: rtl/signed_minmax_tracker_cmp.sv
`default_nettype none
// ============================================================================
// Module      : signed_cmp
// Description : Combinational 2's-complement compare, sign bit decides first.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-2:0] w_mag_a;
    logic [WIDTH-2:0] w_mag_b;

    assign w_sign_a = i_a[WIDTH-1];
    assign w_sign_b = i_b[WIDTH-1];
    assign w_mag_a  = i_a[WIDTH-2:0];
    assign w_mag_b  = i_b[WIDTH-2:0];

    always_comb begin
        gt = 1'b0;
        lt = 1'b0;
        if (w_sign_a != w_sign_b) begin
            // A clear sign bit means non-negative, which outranks any negative.
            gt = w_sign_b;
            lt = w_sign_a;
        end else begin
            gt = (w_mag_a > w_mag_b);
            lt = (w_mag_a < w_mag_b);
        end
    end

    assign eq = (i_a == i_b);

endmodule : signed_cmp
`default_nettype wire

// File: rtl/signed_minmax_tracker.sv
`default_nettype none
// ============================================================================
// Module      : signed_minmax_tracker
// Description : Per-frame signed minimum/maximum with first-occurrence
//               indices and sample count over a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_minmax_tracker
    import minmax_pkg::*;
#(
    parameter int WIDTH   = c_default_width,
    parameter int MAX_LEN = c_default_max_len,
    parameter int IDX_W   = $clog2(MAX_LEN),
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    signed_minmax_tracker_if.slave bus
);

    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_LEN);

    state_t r_state;
    state_t w_state_nxt;

    // Running accumulators for the frame in progress
    logic signed [WIDTH-1:0] r_acc_min;
    logic signed [WIDTH-1:0] r_acc_max;
    logic [IDX_W-1:0]        r_acc_min_idx;
    logic [IDX_W-1:0]        r_acc_max_idx;
    logic [CNT_W-1:0]        r_acc_cnt;

    // Published result, only reloaded when a frame closes
    logic signed [WIDTH-1:0] r_out_min;
    logic signed [WIDTH-1:0] r_out_max;
    logic [IDX_W-1:0]        r_out_min_idx;
    logic [IDX_W-1:0]        r_out_max_idx;
    logic [CNT_W-1:0]        r_out_cnt;
    logic                    r_out_trunc;

    logic signed [WIDTH-1:0] w_min_nxt;
    logic signed [WIDTH-1:0] w_max_nxt;
    logic [IDX_W-1:0]        w_min_idx_nxt;
    logic [IDX_W-1:0]        w_max_idx_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;

    logic             w_accept;
    logic             w_first;
    logic             w_full;
    logic             w_close;
    logic [IDX_W-1:0] w_pos;
    logic             w_gt_min;
    logic             w_lt_min;
    logic             w_eq_min;
    logic             w_gt_max;
    logic             w_lt_max;
    logic             w_eq_max;
    logic             w_unused;

    signed_cmp #(.WIDTH(WIDTH)) u_cmp_min (
        .i_a (bus.s_data),
        .i_b (r_acc_min),
        .gt  (w_gt_min),
        .lt  (w_lt_min),
        .eq  (w_eq_min)
    );

    signed_cmp #(.WIDTH(WIDTH)) u_cmp_max (
        .i_a (bus.s_data),
        .i_b (r_acc_max),
        .gt  (w_gt_max),
        .lt  (w_lt_max),
        .eq  (w_eq_max)
    );

    // Only strict lt/gt matter: ties leave the earlier index in place.
    assign w_unused = &{1'b0, w_gt_min, w_eq_min, w_lt_max, w_eq_max};

    assign bus.s_ready = (r_state != HOLD);
    assign w_accept    = bus.s_valid && bus.s_ready;
    assign w_first     = (r_state == IDLE);
    assign w_pos       = r_acc_cnt[IDX_W-1:0];

    always_comb begin
        w_min_nxt     = r_acc_min;
        w_max_nxt     = r_acc_max;
        w_min_idx_nxt = r_acc_min_idx;
        w_max_idx_nxt = r_acc_max_idx;
        w_cnt_nxt     = r_acc_cnt;
        if (w_first) begin
            w_min_nxt     = bus.s_data;
            w_max_nxt     = bus.s_data;
            w_min_idx_nxt = '0;
            w_max_idx_nxt = '0;
            w_cnt_nxt     = c_one;
        end else begin
            if (w_lt_min) begin
                w_min_nxt     = bus.s_data;
                w_min_idx_nxt = w_pos;
            end
            if (w_gt_max) begin
                w_max_nxt     = bus.s_data;
                w_max_idx_nxt = w_pos;
            end
            w_cnt_nxt = r_acc_cnt + c_one;
        end
    end

    assign w_full  = (w_cnt_nxt == c_max_cnt);
    assign w_close = w_accept && (bus.s_last || w_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_close ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (w_close) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_min     <= '0;
            r_acc_max     <= '0;
            r_acc_min_idx <= '0;
            r_acc_max_idx <= '0;
            r_acc_cnt     <= '0;
            r_out_min     <= '0;
            r_out_max     <= '0;
            r_out_min_idx <= '0;
            r_out_max_idx <= '0;
            r_out_cnt     <= '0;
            r_out_trunc   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc_min     <= w_min_nxt;
                r_acc_max     <= w_max_nxt;
                r_acc_min_idx <= w_min_idx_nxt;
                r_acc_max_idx <= w_max_idx_nxt;
                r_acc_cnt     <= w_cnt_nxt;
            end
            if (w_close) begin
                r_out_min     <= w_min_nxt;
                r_out_max     <= w_max_nxt;
                r_out_min_idx <= w_min_idx_nxt;
                r_out_max_idx <= w_max_idx_nxt;
                r_out_cnt     <= w_cnt_nxt;
                r_out_trunc   <= w_full && !bus.s_last;
            end
        end
    end

    assign bus.m_valid   = (r_state == HOLD);
    assign bus.m_min     = r_out_min;
    assign bus.m_max     = r_out_max;
    assign bus.m_min_idx = r_out_min_idx;
    assign bus.m_max_idx = r_out_max_idx;
    assign bus.m_count   = r_out_cnt;
    assign bus.m_trunc   = r_out_trunc;

endmodule : signed_minmax_tracker
`default_nettype wire

// File: doc/signed_minmax_tracker.md
# signed_minmax_tracker

Streaming signed min/max tracker. It accepts 2's-complement samples over a valid/ready stream and groups them into frames delimited by `s_last`. For each frame it reports the minimum, the maximum, the index of each, and the sample count on a valid/ready result port. It sits downstream of the sample sources and is the sequential consumer of the team's signed magnitude comparison.

## Interface
- `WIDTH`, default 8: sample width in bits, 2's complement; must be ≥ 2.
- `MAX_LEN`, default 16: maximum number of samples per frame; must be ≥ 2.
- `IDX_W`, default `$clog2(MAX_LEN)`: width of the index outputs.
- `CNT_W`, default `$clog2(MAX_LEN+1)`: width of the count output.
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  a sample is offered.
- `s_ready`  out  1  the block can accept a sample.
- `s_data`  in  WIDTH  sample, signed.
- `s_last`  in  1  marks the last sample of the frame.
- `m_valid`  out  1  a frame result is available.
- `m_ready`  in  1  the downstream consumer takes the result.
- `m_min`, `m_max`  out  WIDTH  signed frame minimum and maximum.
- `m_min_idx`, `m_max_idx`  out  IDX_W  position in the frame of the first occurrence of each extreme.
- `m_count`  out  CNT_W  number of samples in the frame (1..MAX_LEN).
- `m_trunc`  out  1  frame was closed at MAX_LEN without `s_last`.

## Operation
- A sample is accepted when `s_valid && s_ready`.
- States:
  - `IDLE`: no samples in the frame yet.
  - `ACCUM`: at least one sample accepted.
  - `HOLD`: result presented on the `m_*` port.
- `IDLE`, on accept:
  - min and max both take `s_data`; both indices = 0; count = 1.
  - Go to `HOLD` if `s_last`, otherwise to `ACCUM`.
- `ACCUM`, on accept at position p = count:
  - If `s_data` < min (strictly less, signed), min takes `s_data` and min_idx = p.
  - If `s_data` > max (strictly greater, signed), max takes `s_data` and max_idx = p.
  - Ties keep the earlier index.
  - count increments.
- Frame close:
  - The frame closes on an accepted sample with `s_last`, or on the accepted sample that makes count = MAX_LEN.
  - `m_trunc` = 1 only when the frame closed at MAX_LEN and that sample had `s_last` = 0.
  - State goes to `HOLD`.
- `HOLD`:
  - `m_valid` = 1; all `m_*` outputs are held stable.
  - On `m_ready`, go to `IDLE` in the next cycle.
- Signed comparison:
  - The sign bit decides first: non-negative is greater than negative.
  - With equal sign bits, the remaining bits are compared as unsigned, MSB first.
  - The result is equivalent to `$signed` compare.
- No arithmetic is performed on samples, so no widening or saturation applies.

## Timing
- Reset state: `IDLE`, `s_ready` = 1, `m_valid` = 0, and every `m_*` data output = 0.
- `rst_n` low mid-frame or mid-`HOLD` discards the partial frame or pending result immediately (asynchronous).
- `s_ready` = (state != `HOLD`), driven as a registered state decode.
  - It has no combinational path from `m_ready`.
  - It is 0 during the `HOLD` cycle in which the result handshake completes.
  - It returns to 1 in the following cycle.
- Latency: `m_valid` rises in the cycle after the closing sample is accepted.
- Throughput: one sample per cycle inside a frame, plus at least 2 cycles between frames (the `HOLD` cycle(s) and the return to `IDLE`).
- `m_valid` stays high and the outputs stay unchanged until `m_ready` is sampled high.
- `m_*` outputs are registered. After the handshake they keep their last values until the next frame closes.
- `s_last` and `s_data` are ignored when `s_valid` = 0.

## Structure
- Package `minmax_pkg`: state enum `{IDLE, ACCUM, HOLD}` and the default WIDTH/MAX_LEN localparams.
- Sub-module `signed_cmp` (combinational, parameter WIDTH):
  - Outputs `gt`, `lt`, `eq`.
  - Sign-bit-first compare as described above.
  - Instantiated twice: `s_data` vs min, `s_data` vs max.
- Top level holds the FSM, the sample counter, and the min/max/index registers.

## Test plan
- Frame {5, -3, 127, -128, 0} with `s_last` on the 0 → min = -128 (idx 3), max = 127 (idx 2), count 5, trunc 0; `m_valid` one cycle after the last accept.
- Tie frame {-1, -1, -1} → min = max = -1, both idx 0, count 3.
- Single-sample frame 42 with `s_last` → min = max = 42, idx 0, count 1, trunc 0.
- Sixteen samples 0..15 with no `s_last` (MAX_LEN = 16) → close after the 16th, min 0 (idx 0), max 15 (idx 15), count 16, trunc 1; the 17th sample starts a new frame.
- Sign boundary frame {0, -1, 1, -128, 127}, then `m_ready` held low for 5 cycles → min -128 (idx 3), max 127 (idx 4); outputs stable and `s_ready` = 0 throughout the stall.
- `rst_n` pulsed low after 3 samples of a frame → all outputs 0 and `s_ready` = 1 at once; the next frame {7, 2} with `s_last` gives min 2 (idx 1), max 7 (idx 0), count 2.
